multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
Control FSM that sequences the multicycle MIPS datapath for the computer's CPU, which shares one memory port between instruction and data. It steps each instruction through fetch, decode, execute, memory and writeback states. It drives the datapath mux selects and the write enables, and it stalls on a memory-ready handshake. It also contains the ALU function decoder.

Parameters:
RESET_STATE, FETCH (state code 4'd0), state entered on reset
ILLEGAL_TRAP, 0, 1 = halt in state TRAP on an illegal opcode or funct; 0 = raise illegalOp and return to FETCH

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  6  instr[31:26] from the instruction register
funct  input  6  instr[5:0] from the instruction register
zero  input  1  ALU zero flag
memReady  input  1  memory has completed the current read or write this cycle
iOrD  output  1  memory address select: 0 = PC, 1 = ALUOut
memWrite  output  1  data memory write enable
irWrite  output  1  instruction register load
regDst  output  1  destination register: 0 = rt, 1 = rd
memToReg  output  1  writeback source: 0 = ALUOut, 1 = MDR
regWrite  output  1  register file write enable
aluSrcA  output  1  ALU A input: 0 = PC, 1 = regA
aluSrcB  output  2  ALU B input: 00 = regB, 01 = 4, 10 = SignImm, 11 = SignImm<<2
aluControl  output  3  ALU function
pcSrc  output  2  next PC: 00 = ALUResult, 01 = ALUOut, 10 = jump target
pcWrite  output  1  PC load, already including the branch condition
illegalOp  output  1  one-cycle pulse when an unsupported opcode or funct is decoded
state  output  4  current state, for debug only

Behaviour:
- Reset:
  - Asynchronous reset forces state = FETCH.
  - While reset is high, all enables are forced to 0: memWrite, irWrite, regWrite, pcWrite, illegalOp.
  - The mux selects take their FETCH values during reset.
- Output style:
  - Moore outputs decoded from state.
  - Exceptions: pcWrite and irWrite in FETCH are qualified by memReady. pcWrite in BRANCH equals zero.
  - Any signal not listed for a state is 0.
- States and outputs (encodings 0..12):
  - FETCH(0): iOrD=0, aluSrcA=0, aluSrcB=01, ALU add, pcSrc=00, irWrite=pcWrite=memReady. Goes to DECODE only when memReady=1, otherwise holds.
  - DECODE(1): aluSrcA=0, aluSrcB=11, ALU add (precomputes the branch target).
    - Next state by opcode: 000000 -> EXECUTE; 100011 (lw) or 101011 (sw) -> MEMADR; 000100 (beq) -> BRANCH; 001000 (addi) -> ADDIEX; 000010 (j) -> JUMP.
    - Any other opcode -> illegal handling.
  - MEMADR(2): aluSrcA=1, aluSrcB=10, ALU add. Goes to MEMRD for lw, MEMWR for sw.
  - MEMRD(3): iOrD=1. Holds until memReady, then goes to MEMWB.
  - MEMWB(4): regDst=0, memToReg=1, regWrite=1, then FETCH.
  - MEMWR(5): iOrD=1, memWrite=1. memWrite is held until memReady; on memReady goes to FETCH.
  - EXECUTE(6): aluSrcA=1, aluSrcB=00, ALU function from funct.
    - funct 100000 -> 010 (add); 100010 -> 110 (sub); 100100 -> 000 (and); 100101 -> 001 (or); 101010 -> 111 (slt).
    - Legal funct -> ALUWB. Other funct -> illegal handling, with aluControl=010.
  - ALUWB(7): regDst=1, memToReg=0, regWrite=1, then FETCH.
  - BRANCH(8): aluSrcA=1, aluSrcB=00, aluControl=110, pcSrc=01, pcWrite=zero, then FETCH.
  - ADDIEX(9): aluSrcA=1, aluSrcB=10, ALU add, then ADDIWB.
  - ADDIWB(10): regDst=0, memToReg=0, regWrite=1, then FETCH.
  - JUMP(11): pcSrc=10, pcWrite=1, then FETCH.
  - TRAP(12): no enables asserted. Exits only by reset.
- Illegal handling:
  - illegalOp is asserted for the one cycle in DECODE or EXECUTE where the bad code is decoded.
  - Next state is TRAP if ILLEGAL_TRAP=1, otherwise FETCH. No register or memory write occurs.
- Latency with memReady tied to 1:
  - 3 cycles: beq, j.
  - 4 cycles: R-type, sw, addi.
  - 5 cycles: lw.
  - Each cycle memReady=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Unreachable state codes (13..15) go to FETCH on the next edge, with all enables 0.
- Reset asserted mid-instruction: abandon immediately, with no partial write on the reset cycle.

Decomposition:
- Package mc_pkg: state_t enum (4-bit), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), funct constants, ALU control constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_SLT), and the aluOp encoding.
- One sub-module, alu_decoder (combinational):
  - Inputs: aluOp[1:0] and funct.
  - Outputs: aluControl and a funct-legal flag.
  - Instantiated by multicycle_controller.

Test Plan:
- Reset, then lw (opcode 100011) with memReady=1 -> states 0,1,2,3,4,0. regWrite=1 and memToReg=1 only in state 4. irWrite=1 only in cycle 1.
- sw with memReady low for 3 cycles in MEMWR -> memWrite=1 held for 4 cycles with iOrD=1, then FETCH. No regWrite at any point.
- beq with zero=1 -> pcWrite=1 and pcSrc=01 in BRANCH. Repeat with zero=0 -> pcWrite=0. Both runs take 3 cycles.
- R-type funct 101010 -> aluControl=111 in EXECUTE, regDst=1 and regWrite=1 in ALUWB. funct 000111 -> illegalOp pulse, no regWrite, return to FETCH (ILLEGAL_TRAP=0).
- Opcode 111111 with ILLEGAL_TRAP=1 -> state 12 held for 10 cycles with all enables 0. Reset returns the FSM to FETCH.
- Reset asserted in MEMWR while memReady=0 -> memWrite drops to 0 in the same cycle and state=0. FETCH stalls while memReady=0, with pcWrite=irWrite=0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS control FSM and its ALU decoder.
package mc_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11,
        S_TRAP    = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // IDLE drives aluControl to 000 in states that do not use the ALU.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IDLE  = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_decoder.sv
// ALU function decoder: maps aluOp and the R-type funct field to aluControl.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] aluOp_i,
    input  logic [5:0] funct_i,
    output logic [2:0] aluControl_o,
    output logic       functLegal_o
);

    always_comb begin
        aluControl_o = ALU_ADD;
        functLegal_o = 1'b1;
        case (aluOp_i)
            ALUOP_ADD: aluControl_o = ALU_ADD;
            ALUOP_SUB: aluControl_o = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct_i)
                    FN_ADD:  aluControl_o = ALU_ADD;
                    FN_SUB:  aluControl_o = ALU_SUB;
                    FN_AND:  aluControl_o = ALU_AND;
                    FN_OR:   aluControl_o = ALU_OR;
                    FN_SLT:  aluControl_o = ALU_SLT;
                    default: functLegal_o = 1'b0;
                endcase
            end
            ALUOP_IDLE: aluControl_o = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM sequencing the shared-memory multicycle MIPS datapath.
// state | meaning: FETCH read instr, PC+4 | DECODE branch target | MEMADR lw/sw addr | MEMRD/MEMWB load
//       | MEMWR store | EXECUTE/ALUWB R-type | BRANCH beq | ADDIEX/ADDIWB addi | JUMP j | TRAP halted
module multicycle_controller
    import mc_pkg::*;
#(
    parameter state_t RESET_STATE  = S_FETCH,
    parameter logic   ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       memReady,
    output logic       iOrD,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [2:0] aluControl,
    output logic [1:0] pcSrc,
    output logic       pcWrite,
    output logic       illegalOp,
    output logic [3:0] state
);

    state_t     state_q, state_d;
    logic [1:0] aluOp;
    logic       functLegal;
    state_t     illegal_next;

    assign illegal_next = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
    assign state        = state_q;

    alu_decoder u_alu_decoder (
        .aluOp_i      (aluOp),
        .funct_i      (funct),
        .aluControl_o (aluControl),
        .functLegal_o (functLegal)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= RESET_STATE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        iOrD      = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        regDst    = 1'b0;
        memToReg  = 1'b0;
        regWrite  = 1'b0;
        aluSrcA   = 1'b0;
        aluSrcB   = 2'b00;
        aluOp     = ALUOP_IDLE;
        pcSrc     = 2'b00;
        pcWrite   = 1'b0;
        illegalOp = 1'b0;
        case (state_q)
            S_FETCH: begin
                aluSrcB = 2'b01;
                aluOp   = ALUOP_ADD;
                irWrite = memReady;
                pcWrite = memReady;
                if (memReady) state_d = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                aluOp   = ALUOP_ADD;
                case (opcode)
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        illegalOp = 1'b1;
                        state_d   = illegal_next;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = ALUOP_ADD;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                iOrD = 1'b1;
                if (memReady) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                memToReg = 1'b1;
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                iOrD     = 1'b1;
                memWrite = 1'b1;
                if (memReady) state_d = S_FETCH;
            end
            S_EXECUTE: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_FUNCT;
                if (functLegal) begin
                    state_d = S_ALUWB;
                end else begin
                    illegalOp = 1'b1;
                    state_d   = illegal_next;
                end
            end
            S_ALUWB: begin
                regDst   = 1'b1;
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;
                aluOp   = ALUOP_SUB;
                pcSrc   = 2'b01;
                pcWrite = zero;
                state_d = S_FETCH;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = ALUOP_ADD;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                regWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_JUMP: begin
                pcSrc   = 2'b10;
                pcWrite = 1'b1;
                state_d = S_FETCH;
            end
            S_TRAP: state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
        // Reset abandons the instruction at once; no write may leak out on that cycle.
        if (reset) begin
            memWrite  = 1'b0;
            irWrite   = 1'b0;
            regWrite  = 1'b0;
            pcWrite   = 1'b0;
            illegalOp = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: two controllers (ILLEGAL_TRAP=0 and =1) share stimulus, each checked every cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic       zero = 1'b0, memReady = 1'b0;

    logic       iOrD0, memWrite0, irWrite0, regDst0, memToReg0, regWrite0, aluSrcA0, pcWrite0, illegalOp0;
    logic [1:0] aluSrcB0, pcSrc0;
    logic [2:0] aluControl0;
    logic [3:0] state0;
    logic       iOrD1, memWrite1, irWrite1, regDst1, memToReg1, regWrite1, aluSrcA1, pcWrite1, illegalOp1;
    logic [1:0] aluSrcB1, pcSrc1;
    logic [2:0] aluControl1;
    logic [3:0] state1;

    always #5 clk = ~clk;

    multicycle_controller #(.ILLEGAL_TRAP(1'b0)) dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .memReady(memReady),
        .iOrD(iOrD0), .memWrite(memWrite0), .irWrite(irWrite0), .regDst(regDst0), .memToReg(memToReg0),
        .regWrite(regWrite0), .aluSrcA(aluSrcA0), .aluSrcB(aluSrcB0), .aluControl(aluControl0),
        .pcSrc(pcSrc0), .pcWrite(pcWrite0), .illegalOp(illegalOp0), .state(state0)
    );

    multicycle_controller #(.ILLEGAL_TRAP(1'b1)) dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero), .memReady(memReady),
        .iOrD(iOrD1), .memWrite(memWrite1), .irWrite(irWrite1), .regDst(regDst1), .memToReg(memToReg1),
        .regWrite(regWrite1), .aluSrcA(aluSrcA1), .aluSrcB(aluSrcB1), .aluControl(aluControl1),
        .pcSrc(pcSrc1), .pcWrite(pcWrite1), .illegalOp(illegalOp1), .state(state1)
    );

    // Packed as {state, iOrD, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA, aluSrcB, aluControl, pcSrc, pcWrite, illegalOp}
    logic [19:0] got0, got1;
    assign got0 = {state0, iOrD0, memWrite0, irWrite0, regDst0, memToReg0, regWrite0, aluSrcA0,
                   aluSrcB0, aluControl0, pcSrc0, pcWrite0, illegalOp0};
    assign got1 = {state1, iOrD1, memWrite1, irWrite1, regDst1, memToReg1, regWrite1, aluSrcA1,
                   aluSrcB1, aluControl1, pcSrc1, pcWrite1, illegalOp1};

    typedef struct {
        string       nm;
        logic [19:0] v;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   total = 0;
    int   bad = 0;
    logic       rst_v = 1'b1;
    logic [5:0] nxt_op = 6'd0, nxt_fn = 6'd0;

    // Expected outputs from the state/output table of the controller description.
    function automatic logic [19:0] exp_vec(input int s, input logic rst, input logic mr, input logic z,
                                            input logic [2:0] alu_ex, input logic ill);
        logic [3:0] st;
        logic iord, mw, irw, rd, m2r, rw, asa, pw, il;
        logic [1:0] asb, pcs;
        logic [2:0] ac;
        st = 4'(s);
        {iord, mw, irw, rd, m2r, rw, asa, pw} = 8'd0;
        asb = 2'b00; pcs = 2'b00; ac = 3'b000; il = ill;
        case (s)
            0:  begin asb = 2'b01; ac = 3'b010; irw = mr; pw = mr; end
            1:  begin asb = 2'b11; ac = 3'b010; end
            2:  begin asa = 1'b1; asb = 2'b10; ac = 3'b010; end
            3:  iord = 1'b1;
            4:  begin m2r = 1'b1; rw = 1'b1; end
            5:  begin iord = 1'b1; mw = 1'b1; end
            6:  begin asa = 1'b1; ac = alu_ex; end
            7:  begin rd = 1'b1; rw = 1'b1; end
            8:  begin asa = 1'b1; ac = 3'b110; pcs = 2'b01; pw = z; end
            9:  begin asa = 1'b1; asb = 2'b10; ac = 3'b010; end
            10: rw = 1'b1;
            11: begin pcs = 2'b10; pw = 1'b1; end
            default: ;
        endcase
        if (rst) begin mw = 1'b0; irw = 1'b0; rw = 1'b0; pw = 1'b0; il = 1'b0; end
        return {st, iord, mw, irw, rd, m2r, rw, asa, asb, ac, pcs, pw, il};
    endfunction

    task automatic cyc(input string nm, input logic mr, input logic z, input int s0, input int s1,
                       input logic [2:0] alu, input logic ill0, input logic ill1);
        exp_t e;
        @(posedge clk);
        #1;
        reset = rst_v; memReady = mr; zero = z; opcode = nxt_op; funct = nxt_fn;
        e.nm = nm;
        e.v = exp_vec(s0, rst_v, mr, z, alu, ill0);
        q0.push_back(e);
        e.v = exp_vec(s1, rst_v, mr, z, alu, ill1);
        q1.push_back(e);
    endtask

    task automatic same(input string nm, input logic mr, input logic z, input int s,
                        input logic [2:0] alu, input logic ill);
        cyc(nm, mr, z, s, s, alu, ill, ill);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            total++;
            if (got0 !== e.v) begin
                bad++;
                $display("FAIL %s dut0(trap=0) got=%05h expected=%05h", e.nm, got0, e.v);
            end
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            total++;
            if (got1 !== e.v) begin
                bad++;
                $display("FAIL %s dut1(trap=1) got=%05h expected=%05h", e.nm, got1, e.v);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    logic [5:0] rfn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] ral [5] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    initial begin
        rst_v = 1'b1;
        same("rst_hold_a", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("rst_hold_b", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        rst_v = 1'b0;

        nxt_op = 6'b100011;
        same("lw_fetch_stall", 1'b0, 1'b0, 0, 3'b0, 1'b0);
        same("lw_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("lw_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);
        same("lw_memadr", 1'b1, 1'b0, 2, 3'b0, 1'b0);
        same("lw_memrd", 1'b1, 1'b0, 3, 3'b0, 1'b0);
        same("lw_memwb", 1'b1, 1'b0, 4, 3'b0, 1'b0);

        nxt_op = 6'b101011;
        same("sw_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("sw_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);
        same("sw_memadr", 1'b1, 1'b0, 2, 3'b0, 1'b0);
        for (int i = 0; i < 3; i++) same("sw_memwr_wait", 1'b0, 1'b0, 5, 3'b0, 1'b0);
        same("sw_memwr_done", 1'b1, 1'b0, 5, 3'b0, 1'b0);

        nxt_op = 6'b000100;
        for (int k = 1; k >= 0; k--) begin
            same("beq_fetch", 1'b1, 1'(k), 0, 3'b0, 1'b0);
            same("beq_decode", 1'b1, 1'(k), 1, 3'b0, 1'b0);
            same("beq_branch", 1'b1, 1'(k), 8, 3'b0, 1'b0);
        end

        nxt_op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            nxt_fn = rfn[i];
            same("r_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
            same("r_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);
            same("r_execute", 1'b1, 1'b0, 6, ral[i], 1'b0);
            same("r_aluwb", 1'b1, 1'b0, 7, 3'b0, 1'b0);
        end

        nxt_op = 6'b001000;
        same("addi_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("addi_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);
        same("addi_ex", 1'b1, 1'b0, 9, 3'b0, 1'b0);
        same("addi_wb", 1'b1, 1'b0, 10, 3'b0, 1'b0);

        nxt_op = 6'b000010;
        same("j_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("j_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);
        same("j_jump", 1'b1, 1'b0, 11, 3'b0, 1'b0);

        nxt_op = 6'b000000; nxt_fn = 6'b000111;
        same("badfn_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("badfn_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);
        same("badfn_execute", 1'b1, 1'b0, 6, 3'b010, 1'b1);
        for (int i = 0; i < 2; i++) cyc("badfn_after", 1'b0, 1'b0, 0, 12, 3'b0, 1'b0, 1'b0);
        rst_v = 1'b1;
        same("badfn_reset", 1'b0, 1'b0, 0, 3'b0, 1'b0);
        rst_v = 1'b0;

        nxt_op = 6'b111111; nxt_fn = 6'b100000;
        same("badop_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("badop_decode", 1'b1, 1'b0, 1, 3'b0, 1'b1);
        for (int i = 0; i < 10; i++) cyc("badop_trap_hold", 1'b0, 1'b0, 0, 12, 3'b0, 1'b0, 1'b0);
        rst_v = 1'b1;
        same("badop_reset", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        rst_v = 1'b0;
        same("after_trap_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("after_trap_decode", 1'b1, 1'b0, 1, 3'b0, 1'b1);
        cyc("after_trap_again", 1'b0, 1'b0, 0, 12, 3'b0, 1'b0, 1'b0);
        rst_v = 1'b1;
        same("rst_again", 1'b0, 1'b0, 0, 3'b0, 1'b0);
        rst_v = 1'b0;

        nxt_op = 6'b101011;
        same("swr_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("swr_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);
        same("swr_memadr", 1'b1, 1'b0, 2, 3'b0, 1'b0);
        same("swr_memwr_wait", 1'b0, 1'b0, 5, 3'b0, 1'b0);
        rst_v = 1'b1;
        same("swr_reset_midwrite", 1'b0, 1'b0, 0, 3'b0, 1'b0);
        rst_v = 1'b0;
        for (int i = 0; i < 3; i++) same("post_reset_fetch_stall", 1'b0, 1'b0, 0, 3'b0, 1'b0);
        same("post_reset_fetch", 1'b1, 1'b0, 0, 3'b0, 1'b0);
        same("post_reset_decode", 1'b1, 1'b0, 1, 3'b0, 1'b0);

        @(negedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain left0=%0d left1=%0d required=0", q0.size(), q1.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
